// File: rtl/ram_stream_dma.sv
// ram_stream_dma: bus initiator moving a block of bytes between a synchronous
// single-port byte RAM and a valid/ready byte stream, in either direction.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start, dir          command pulse (sampled in IDLE); 0 = stream->RAM, 1 = RAM->stream
//   base, len           first RAM address and byte count, latched on start
//   busy, done          transfer in progress; one-cycle completion pulse
//   in_data/valid/ready write-direction stream (sink side)
//   out_data/valid/ready read-direction stream (source side)
//   ram_cs/we/addr/wdata registered RAM strobes; ram_rdata valid the cycle after a read strobe
//   csum                running 16-bit sum of transferred bytes (only with RAM_STREAM_DMA_CSUM_EN)
//
// Optional feature macro: RAM_STREAM_DMA_CSUM_EN adds the csum output.
module ram_stream_dma #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_STREAM_DMA_CSUM_EN
  ,
  output logic [15:0]           csum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   rem_xfer;   // write: bytes left to accept; read: reads left to issue
  logic [LEN_WIDTH-1:0]   rem_pop;    // read: bytes left to hand to the sink
  logic                   rd_pend;    // read data is on ram_rdata this cycle
  logic                   rd_strobe;
  logic [DATA_WIDTH-1:0]  fifo_mem [2];
  logic                   fifo_wp, fifo_rp;
  logic [1:0]             fifo_count;
  logic [2:0]             occupancy;
  logic                   wr_hs, pop, push, issue;

  assign rd_strobe = ram_cs & ~ram_we;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[fifo_rp];
  assign pop       = out_valid & out_ready;
  assign push      = rd_pend;
  assign wr_hs     = in_ready & in_valid;

  // Slots already claimed: FIFO entries plus the strobe on the bus and the
  // data returning from the previous strobe; a same-cycle pop frees one.
  assign occupancy = 3'(fifo_count) + 3'(rd_strobe) + 3'(rd_pend) - 3'(pop);
  assign issue     = (state == S_RD) && (rem_xfer != '0) && (occupancy < 3'd2);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)
            state_nx = S_FIN;
          else
            state_nx = dir ? S_RD : S_WR;
        end
      end
      S_WR: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && (rem_xfer == LEN_WIDTH'(1)))
          state_nx = S_FIN;
      end
      S_RD: begin
        busy = 1'b1;
        if (pop && (rem_pop == LEN_WIDTH'(1)))
          state_nx = S_FIN;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      rem_xfer    <= '0;
      rem_pop     <= '0;
      rd_pend     <= 1'b0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      state   <= state_nx;
      ram_cs  <= 1'b0;
      ram_we  <= 1'b0;
      rd_pend <= rd_strobe;

      case (state)
        S_IDLE: begin
          if (start) begin
            addr     <= base;
            rem_xfer <= len;
            rem_pop  <= len;
          end
        end
        S_WR: begin
          if (wr_hs) begin
            ram_cs    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= addr;
            ram_wdata <= in_data;
            addr      <= addr + ADDR_WIDTH'(1);
            rem_xfer  <= rem_xfer - LEN_WIDTH'(1);
          end
        end
        S_RD: begin
          if (issue) begin
            ram_cs   <= 1'b1;
            ram_addr <= addr;
            addr     <= addr + ADDR_WIDTH'(1);
            rem_xfer <= rem_xfer - LEN_WIDTH'(1);
          end
          if (pop)
            rem_pop <= rem_pop - LEN_WIDTH'(1);
        end
        default: ;
      endcase

      if (push) begin
        fifo_mem[fifo_wp] <= ram_rdata;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop)
        fifo_rp <= ~fifo_rp;
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
    end
  end

`ifdef RAM_STREAM_DMA_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset)
      csum <= '0;
    else if (state == S_IDLE && start)
      csum <= '0;
    else if (wr_hs)
      csum <= csum + 16'(in_data);
    else if (pop)
      csum <= csum + 16'(out_data);
  end
`endif

endmodule

// File: tb/tb_ram_stream_dma.sv
`timescale 1ns/1ps
module tb_ram_stream_dma;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef RAM_STREAM_DMA_CSUM_EN
  logic [15:0]   csum;
`endif

  ram_stream_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .base(base), .len(len),
    .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef RAM_STREAM_DMA_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int cs_cnt = 0;
  int cyc_n = 0;

  logic [7:0]  mem    [65536];
  logic [7:0]  shadow [65536];
  logic [23:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  src_q [$];
  logic [7:0]  got_q [$];
  int          wr_cyc_q [$];
  logic [15:0] wr_addr_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM: registered read data one cycle after the strobe.
  initial begin
    forever begin
      @(posedge clk);
      if (ram_cs) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
      end
    end
  end

  // Transaction-level reference: tracks bytes remaining and checks every cycle.
  initial begin
    bit          m_active, m_fin, m_dir;
    int          m_left;
    logic [15:0] m_sum;
    logic [23:0] e;
    m_active = 1'b0; m_fin = 1'b0; m_dir = 1'b0; m_left = 0; m_sum = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (reset) begin
        m_active = 1'b0; m_fin = 1'b0; m_left = 0; m_sum = '0;
      end else begin
        vectors++;
        assert (dut.fifo_count <= 2'd2) else begin
          miscompares++;
          $display("FAIL fifo_count: got %0d required <= 2", dut.fifo_count);
        end
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_fin));
        chk("in_ready", 32'(in_ready), 32'(m_active && !m_dir));
        if (!(m_active && m_dir)) chk("out_valid_idle", 32'(out_valid), 32'd0);
        if (!m_active && !m_fin)  chk("ram_cs_idle", 32'(ram_cs), 32'd0);
        if (ram_cs) cs_cnt++;
        if (ram_cs && ram_we) begin
          wr_cnt++;
          wr_cyc_q.push_back(cyc_n);
          wr_addr_q.push_back(ram_addr);
          chk("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
          if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            chk("write_addr", 32'(ram_addr), 32'(e[23:8]));
            chk("write_data", 32'(ram_wdata), 32'(e[7:0]));
          end
        end
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          chk("pop_expected", 32'(exp_rd_q.size() != 0), 32'd1);
          if (exp_rd_q.size() != 0)
            chk("out_data", 32'(out_data), 32'(exp_rd_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
`ifdef RAM_STREAM_DMA_CSUM_EN
          chk("csum_at_done", 32'(csum), 32'(m_sum));
`endif
        end
        if (m_fin) begin
          m_fin = 1'b0;
        end else if (m_active) begin
          if (!m_dir ? (in_valid && in_ready) : (out_valid && out_ready)) begin
            m_sum  = m_sum + 16'(!m_dir ? in_data : out_data);
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_active = 1'b0;
              m_fin    = 1'b1;
            end
          end
        end else if (start) begin
          m_sum = '0;
          if (len == '0) m_fin = 1'b1;
          else begin
            m_active = 1'b1;
            m_dir    = dir;
            m_left   = int'(len);
          end
        end
      end
    end
  end

  // mode: 0 = stream always ready/valid, 1 = out_ready 1,0,0 pattern, 2 = random gaps.
  // poke: fire a second start during the transfer.
  task automatic run_xfer(input bit d, input logic [15:0] b, input int n,
                          input int mode, input bit poke);
    int d0, w0, idx, cyc;
    bit hs;
    logic [15:0] a;
    d0 = done_cnt; w0 = wr_cnt;
    for (int i = 0; i < n; i++) begin
      a = b + 16'(i);
      if (!d) begin
        exp_wr_q.push_back({a, src_q[i]});
        shadow[a] = src_q[i];
      end else begin
        exp_rd_q.push_back(shadow[a]);
      end
    end
    @(posedge clk); #1;
    start = 1'b1; dir = d; base = b; len = LW'(n);
    @(posedge clk); #1;
    start = 1'b0; dir = ~d; base = 16'($urandom); len = LW'($urandom);
    idx = 0; cyc = 0;
    while (done_cnt == d0 && cyc < 600) begin
      if (!d) begin
        in_valid = (idx < n) && (mode == 0 || $urandom_range(0, 2) != 0);
        in_data  = in_valid ? src_q[idx] : 8'($urandom);
      end else begin
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      end
      if (poke && cyc == 2) begin
        start = 1'b1; dir = ~d; base = 16'h5555; len = 11'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    chk("xfer_done_count", 32'(done_cnt - d0), 32'd1);
    chk("xfer_write_count", 32'(wr_cnt - w0), d ? 32'd0 : 32'(n));
    chk("xfer_queues_drained", 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
  endtask

  initial begin
    int d0, c0, diffs;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      shadow[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // Write burst
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    wr_cyc_q.delete();
    run_xfer(1'b0, 16'h0100, 4, 0, 1'b0);
    chk("burst_mem0", 32'(mem[16'h0100]), 32'h0A1);
    chk("burst_mem1", 32'(mem[16'h0101]), 32'h0B2);
    chk("burst_mem2", 32'(mem[16'h0102]), 32'h0C3);
    chk("burst_mem3", 32'(mem[16'h0103]), 32'h0D4);
    chk("burst_nwrites", 32'(wr_cyc_q.size()), 32'd4);
    if (wr_cyc_q.size() == 4)
      chk("burst_consecutive", 32'(wr_cyc_q[3] - wr_cyc_q[0]), 32'd3);
    chk("burst_busy_after", 32'(busy), 32'd0);
`ifdef RAM_STREAM_DMA_CSUM_EN
    chk("burst_csum", 32'(csum), 32'h02EA);
`endif

    // Read with backpressure
    for (int i = 0; i < 6; i++) begin
      mem[16'h0200 + 16'(i)]    = 8'h10 + 8'(i);
      shadow[16'h0200 + 16'(i)] = 8'h10 + 8'(i);
    end
    got_q.delete();
    run_xfer(1'b1, 16'h0200, 6, 1, 1'b0);
    chk("bp_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk("bp_byte", 32'(got_q[i]), 32'h10 + 32'(i));

    // Address wrap
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    wr_addr_q.delete();
    run_xfer(1'b0, 16'hFFFE, 4, 2, 1'b0);
    chk("wrap_nwrites", 32'(wr_addr_q.size()), 32'd4);
    if (wr_addr_q.size() == 4) begin
      chk("wrap_a0", 32'(wr_addr_q[0]), 32'hFFFE);
      chk("wrap_a1", 32'(wr_addr_q[1]), 32'hFFFF);
      chk("wrap_a2", 32'(wr_addr_q[2]), 32'h0000);
      chk("wrap_a3", 32'(wr_addr_q[3]), 32'h0001);
    end
    chk("wrap_mem0", 32'(mem[16'h0000]), 32'(src_q[2]));

    // Zero length
    c0 = cs_cnt;
    run_xfer(1'b0, 16'h1234, 0, 0, 1'b0);
    chk("zero_no_cs", 32'(cs_cnt - c0), 32'd0);

    // Reset in the middle of a read, then a fresh short read
    for (int i = 0; i < 8; i++) begin
      mem[16'h0300 + 16'(i)]    = 8'h60 + 8'(i);
      shadow[16'h0300 + 16'(i)] = 8'h60 + 8'(i);
      exp_rd_q.push_back(8'h60 + 8'(i));
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b1; base = 16'h0300; len = 11'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    exp_rd_q.delete();
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);
    got_q.delete();
    run_xfer(1'b1, 16'h0300, 2, 0, 1'b0);
    chk("post_rst_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("post_rst_b0", 32'(got_q[0]), 32'h60);
      chk("post_rst_b1", 32'(got_q[1]), 32'h61);
    end

    // Start while busy
    src_q.delete();
    for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
    run_xfer(1'b0, 16'h0400, 5, 2, 1'b1);

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      int n;
      bit d;
      n = $urandom_range(0, 14);
      d = 1'($urandom_range(0, 1));
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
      run_xfer(d, 16'($urandom), n, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    diffs = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== shadow[i]) diffs++;
    chk("ram_image", 32'(diffs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
